pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Drives per-stage hold and flush to the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles data-bus wait states with a timeout, multi-cycle MDU operations, load-use hazards, taken-branch flushes, and a halt request/acknowledge handshake.
- Also keeps a saturating stall-cycle counter.

Parameters:
TIMEOUT, 256, consecutive data-bus busy cycles before the access is abandoned (>=2)
CNT_W, 32, stall counter width
REG_ADDR_W, 5, register address width

Ports:
clk_100MHz  in  1  system clock
rst  in  1  synchronous, active-high reset
mem_req_i  in  1  MEM stage holds a load/store on the data bus
mem_ack_i  in  1  data bus completes the access this cycle
mdu_busy_i  in  1  EX holds a mul/div op whose result is not ready
id_rs1_re_i  in  1  ID reads rs1
id_rs1_addr_i  in  REG_ADDR_W  ID rs1 address
id_rs2_re_i  in  1  ID reads rs2
id_rs2_addr_i  in  REG_ADDR_W  ID rs2 address
ex_mem_r_ena_i  in  1  EX instruction is a load
ex_reg_w_addr_i  in  REG_ADDR_W  EX destination register
branch_i  in  1  EX resolved a taken branch/jump
halt_req_i  in  1  system halt request (level)
halt_ack_o  out  1  pipeline frozen
hold_o  out  5  hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
flush_o  out  5  bubble into the same registers next edge
bus_err_o  out  1  one-cycle pulse after a data-bus timeout
stall_cnt_o  out  CNT_W  cycles with hold_o[0]=1, saturating

Behaviour:
- Interface (already decided): one clock, clk_100MHz; reset rst is synchronous and active-high.
- Reset: state RUN, wait_cnt=0, stall_cnt_o=0, bus_err_o=0, halt_ack_o=0.
  - While rst=1, hold_o=0 and flush_o=5'b11111 (combinational).
  - rst asserted mid-wait or mid-halt abandons the operation immediately.
- hold_o and flush_o are combinational from state and inputs (zero latency). State, wait_cnt, stall_cnt_o and bus_err_o are registered.
- Derived signals:
  - membusy = mem_req_i & ~mem_ack_i
  - loaduse = ex_mem_r_ena_i & (ex_reg_w_addr_i!=0) & ((id_rs1_re_i & id_rs1_addr_i==ex_reg_w_addr_i) | (id_rs2_re_i & id_rs2_addr_i==ex_reg_w_addr_i))
- Output patterns:
  - MEMSTALL: hold=01111, flush=10000
  - MDUSTALL: hold=00111, flush=01000
  - LUSTALL: hold=00011, flush=00100
  - BRFLUSH: hold=00000, flush=00110
  - FREEZE: hold=11111, flush=00000
  - IDLE: all zero
- RUN state, priority order:
  - membusy: MEMSTALL, wait_cnt<=1, next MEM_WAIT.
  - else mdu_busy_i: MDUSTALL, next MDU_WAIT.
  - else halt_req_i: FREEZE, next HALT.
  - else branch_i: BRFLUSH. branch_i beats loaduse in the same cycle (the ID instruction is wrong-path).
  - else loaduse: LUSTALL for that cycle only.
  - else IDLE.
- MEM_WAIT state:
  - mem_ack_i=1: IDLE (MEM/WB captures the data), next RUN, wait_cnt<=0. Ack on the timeout cycle wins; no error.
  - else wait_cnt==TIMEOUT-1: hold=00000, flush=10000 (faulting instruction replaced by a bubble), next RUN, bus_err_o<=1 for exactly one cycle.
  - else MEMSTALL, wait_cnt++.
  - The timeout cycle is therefore the TIMEOUT-th consecutive busy cycle.
- MDU_WAIT state:
  - membusy: MEMSTALL, wait_cnt<=1, next MEM_WAIT. An older memory access dominates.
  - else mdu_busy_i: MDUSTALL.
  - else IDLE, next RUN.
- HALT state:
  - halt_req_i=1: FREEZE, halt_ack_o=1; branch_i and loaduse are ignored.
  - halt_req_i=0: FREEZE, halt_ack_o=0 at the same edge the state returns to RUN.
- halt_ack_o is registered: it rises the cycle after HALT is entered. A halt request raised during MEM_WAIT or MDU_WAIT is deferred until RUN.
- stall_cnt_o increments on every non-reset cycle with hold_o[0]=1 and sticks at all-ones.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 -> one cycle hold=00011, flush=00100; next cycle IDLE. Same with rd=x0 -> no stall.
- Bus wait: mem_req_i=1, ack on 4th cycle -> hold=01111, flush=10000 for 3 cycles, 4th cycle all zero, bus_err_o=0, stall_cnt_o=3.
- Timeout (TIMEOUT=4), never ack -> cycles 1-3 MEMSTALL; cycle 4 hold=0, flush=10000; cycle 5 bus_err_o=1, state RUN. Ack on cycle 4 -> no error.
- MDU then mem: mdu_busy_i 5 cycles with membusy arriving in cycle 2 -> cycle 1 hold=00111, then MEMSTALL until ack, then MDUSTALL while mdu_busy_i persists.
- Branch+loaduse same cycle -> flush=00110, hold=0. Halt requested during MEM_WAIT -> halt_ack_o rises only after ack+1 cycle; drop request -> ack low, hold=0 next cycle.
- Reset mid-MEM_WAIT: rst=1 one cycle -> flush_o=11111, hold_o=0; afterwards state RUN, stall_cnt_o=0, no bus_err_o pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: per-stage hold/flush, bus timeout, halt handshake.
// Latency: hold_o/flush_o are combinational (zero latency); halt_ack_o, bus_err_o, stall_cnt_o are registered.
// Backpressure: data-bus wait and MDU busy stall upstream stages; a halt request freezes the whole pipe.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT    = 256,
    parameter int CNT_W      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_100MHz,
    input  logic                  rst,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    input  logic                  mdu_busy_i,
    input  logic                  id_rs1_re_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic                  id_rs2_re_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  ex_mem_r_ena_i,
    input  logic [REG_ADDR_W-1:0] ex_reg_w_addr_i,
    input  logic                  branch_i,
    input  logic                  halt_req_i,
    output logic                  halt_ack_o,
    output logic [4:0]            hold_o,
    output logic [4:0]            flush_o,
    output logic                  bus_err_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_MDU_WAIT, S_HALT} state_t;

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    localparam logic [4:0] MEM_HOLD = 5'b01111, MEM_FLUSH = 5'b10000;
    localparam logic [4:0] MDU_HOLD = 5'b00111, MDU_FLUSH = 5'b01000;
    localparam logic [4:0] LU_HOLD  = 5'b00011, LU_FLUSH  = 5'b00100;
    localparam logic [4:0] BR_FLUSH = 5'b00110, ALL_ONES  = 5'b11111;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            bus_err_q, bus_err_d;
    logic            halt_ack_q, halt_ack_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic membusy, loaduse;

    assign membusy = mem_req_i & ~mem_ack_i;
    assign loaduse = ex_mem_r_ena_i & (ex_reg_w_addr_i != '0) &
                     ((id_rs1_re_i & (id_rs1_addr_i == ex_reg_w_addr_i)) |
                      (id_rs2_re_i & (id_rs2_addr_i == ex_reg_w_addr_i)));

    // Next-state and zero-latency hold/flush selection; reset forces a full flush.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = 1'b0;
        halt_ack_d = 1'b0;
        hold_o     = 5'b00000;
        flush_o    = 5'b00000;
        case (state_q)
            S_RUN: begin
                if (membusy) begin
                    hold_o = MEM_HOLD; flush_o = MEM_FLUSH;
                    wait_cnt_d = WC_W'(1);
                    state_d = S_MEM_WAIT;
                end else if (mdu_busy_i) begin
                    hold_o = MDU_HOLD; flush_o = MDU_FLUSH;
                    state_d = S_MDU_WAIT;
                end else if (halt_req_i) begin
                    hold_o = ALL_ONES;
                    state_d = S_HALT;
                end else if (branch_i) begin
                    // The ID instruction is wrong-path, so a load-use stall on it is moot.
                    flush_o = BR_FLUSH;
                end else if (loaduse) begin
                    hold_o = LU_HOLD; flush_o = LU_FLUSH;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack_i) begin
                    // Ack on the timeout cycle still completes the access cleanly.
                    wait_cnt_d = '0;
                    state_d = S_RUN;
                end else if (wait_cnt_q == WC_LAST) begin
                    // Abandon the access: the faulting instruction becomes a bubble.
                    flush_o = MEM_FLUSH;
                    wait_cnt_d = '0;
                    bus_err_d = 1'b1;
                    state_d = S_RUN;
                end else begin
                    hold_o = MEM_HOLD; flush_o = MEM_FLUSH;
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            S_MDU_WAIT: begin
                if (membusy) begin
                    // The older instruction in MEM takes precedence over the MDU op.
                    hold_o = MEM_HOLD; flush_o = MEM_FLUSH;
                    wait_cnt_d = WC_W'(1);
                    state_d = S_MEM_WAIT;
                end else if (mdu_busy_i) begin
                    hold_o = MDU_HOLD; flush_o = MDU_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                hold_o = ALL_ONES;
                if (halt_req_i) halt_ack_d = 1'b1;
                else            state_d = S_RUN;
            end
        endcase
        if (rst) begin
            hold_o  = 5'b00000;
            flush_o = ALL_ONES;
        end
    end

    // State, wait counter, registered flags and saturating stall counter.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
            halt_ack_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
            halt_ack_q <= halt_ack_d;
            if (hold_o[0] && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign halt_ack_o  = halt_ack_q;
    assign bus_err_o   = bus_err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 6;
    localparam int RAW     = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_req = 0, mem_ack = 0, mdu_busy = 0;
    logic rs1_re = 0, rs2_re = 0, ex_ld = 0, branch = 0, halt_req = 0;
    logic [RAW-1:0] rs1_a = '0, rs2_a = '0, ex_rd = '0;
    logic halt_ack, bus_err;
    logic [4:0] hold, flush;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .REG_ADDR_W(RAW)) dut (
        .clk_100MHz(clk), .rst(rst),
        .mem_req_i(mem_req), .mem_ack_i(mem_ack), .mdu_busy_i(mdu_busy),
        .id_rs1_re_i(rs1_re), .id_rs1_addr_i(rs1_a),
        .id_rs2_re_i(rs2_re), .id_rs2_addr_i(rs2_a),
        .ex_mem_r_ena_i(ex_ld), .ex_reg_w_addr_i(ex_rd),
        .branch_i(branch), .halt_req_i(halt_req),
        .halt_ack_o(halt_ack), .hold_o(hold), .flush_o(flush),
        .bus_err_o(bus_err), .stall_cnt_o(stall_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    // ---------------- behavioural reference ----------------
    // Pipeline "situation": how many busy cycles the outstanding bus access has
    // seen (0 = none), whether an MDU op is being waited on, whether frozen.
    int  busy_seen = 0;
    bit  mdu_pending = 0, frozen = 0;
    bit  m_ack = 0, m_err = 0;
    int  m_cnt = 0;

    // Stall causes -> {hold, flush}
    typedef enum int {C_NONE, C_MEM, C_MDU, C_LU, C_BR, C_FRZ, C_DROP, C_RST} cause_t;
    cause_t cause;
    logic [4:0] e_hold, e_flush;

    function automatic logic [9:0] pattern(cause_t c);
        case (c)
            C_MEM:   return {5'b01111, 5'b10000};
            C_MDU:   return {5'b00111, 5'b01000};
            C_LU:    return {5'b00011, 5'b00100};
            C_BR:    return {5'b00000, 5'b00110};
            C_FRZ:   return {5'b11111, 5'b00000};
            C_DROP:  return {5'b00000, 5'b10000};
            C_RST:   return {5'b00000, 5'b11111};
            default: return 10'd0;
        endcase
    endfunction

    wire m_busy = mem_req & ~mem_ack;
    wire m_lu   = ex_ld && ex_rd != 0 &&
                  ((rs1_re && rs1_a == ex_rd) || (rs2_re && rs2_a == ex_rd));
    wire m_timeout = (busy_seen > 0) && !mem_ack && (busy_seen + 1 == TIMEOUT);

    always_comb begin
        cause = C_NONE;
        if (rst)                       cause = C_RST;
        else if (busy_seen > 0)        cause = mem_ack ? C_NONE : (m_timeout ? C_DROP : C_MEM);
        else if (frozen)               cause = C_FRZ;
        else if (m_busy)               cause = C_MEM;
        else if (mdu_busy)             cause = C_MDU;
        else if (!mdu_pending && halt_req) cause = C_FRZ;
        else if (!mdu_pending && branch)   cause = C_BR;
        else if (!mdu_pending && m_lu)     cause = C_LU;
        {e_hold, e_flush} = pattern(cause);
    end

    always @(posedge clk) begin
        if (rst) begin
            busy_seen <= 0; mdu_pending <= 0; frozen <= 0;
            m_ack <= 0; m_err <= 0; m_cnt <= 0;
        end else begin
            if (e_hold[0] && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            m_err <= m_timeout;
            m_ack <= frozen && halt_req;
            if (busy_seen > 0)
                busy_seen <= (mem_ack || m_timeout) ? 0 : busy_seen + 1;
            else if (!frozen && m_busy) begin
                busy_seen <= 1; mdu_pending <= 0;
            end else if (frozen)
                frozen <= halt_req;
            else if (mdu_busy)
                mdu_pending <= 1;
            else if (mdu_pending)
                mdu_pending <= 0;
            else if (halt_req)
                frozen <= 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(string nm, int act, int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
    endtask

    // Literal expectation: pins both the DUT and the model.
    task automatic lit(string nm, int dut_v, int mdl_v, int want);
        check({nm, " dut"}, dut_v, want);
        check({nm, " model"}, mdl_v, want);
    endtask

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("hold", hold, e_hold);
            check("flush", flush, e_flush);
            check("halt_ack", halt_ack, m_ack);
            check("bus_err", bus_err, m_err);
            check("stall_cnt", stall_cnt, m_cnt);
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle_in;
        mem_req = 0; mem_ack = 0; mdu_busy = 0; rs1_re = 0; rs2_re = 0;
        ex_ld = 0; branch = 0; halt_req = 0; rs1_a = 0; rs2_a = 0; ex_rd = 0;
    endtask

    initial begin
        idle_in();
        rst = 1;
        tick(); #2;
        lit("rst hold", hold, e_hold, 0);
        lit("rst flush", flush, e_flush, 5'b11111);
        tick(); rst = 0; #2;
        chk_en = 1;
        lit("rst cnt", stall_cnt, m_cnt, 0);
        lit("rst ack", halt_ack, m_ack, 0);
        lit("rst err", bus_err, m_err, 0);

        // Bus wait, ack on 4th cycle
        mem_req = 1; #2;
        lit("bw c1 hold", hold, e_hold, 5'b01111);
        lit("bw c1 flush", flush, e_flush, 5'b10000);
        tick(); #2; lit("bw c2 hold", hold, e_hold, 5'b01111);
        tick(); #2; lit("bw c3 flush", flush, e_flush, 5'b10000);
        tick(); mem_ack = 1; #2;
        lit("bw c4 hold", hold, e_hold, 0);
        lit("bw c4 flush", flush, e_flush, 0);
        tick(); idle_in(); #2;
        lit("bw cnt", stall_cnt, m_cnt, 3);
        lit("bw err", bus_err, m_err, 0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        ex_ld = 1; ex_rd = 5; rs1_re = 1; rs1_a = 5; rs2_re = 1; rs2_a = 1; #2;
        lit("lu hold", hold, e_hold, 5'b00011);
        lit("lu flush", flush, e_flush, 5'b00100);
        tick(); idle_in(); #2;
        lit("lu after", hold, e_hold, 0);
        ex_ld = 1; ex_rd = 0; rs1_re = 1; rs1_a = 0; #2;
        lit("lu x0", hold, e_hold, 0);

        // Branch + load-use same cycle
        tick(); ex_ld = 1; ex_rd = 7; rs2_re = 1; rs2_a = 7; branch = 1; #2;
        lit("br hold", hold, e_hold, 0);
        lit("br flush", flush, e_flush, 5'b00110);

        // Timeout, never acked
        tick(); idle_in(); mem_req = 1; #2;
        lit("to c1", hold, e_hold, 5'b01111);
        tick(); tick(); #2; lit("to c3", hold, e_hold, 5'b01111);
        tick(); #2;
        lit("to c4 hold", hold, e_hold, 0);
        lit("to c4 flush", flush, e_flush, 5'b10000);
        tick(); mem_req = 0; #2;
        lit("to c5 err", bus_err, m_err, 1);
        lit("to c5 hold", hold, e_hold, 0);
        tick(); #2; lit("to c6 err", bus_err, m_err, 0);

        // MDU then memory
        mdu_busy = 1; #2; lit("mdu c1", hold, e_hold, 5'b00111);
        tick(); mem_req = 1; #2; lit("mdu c2 mem", hold, e_hold, 5'b01111);
        tick(); mem_ack = 1; #2; lit("mdu ack", hold, e_hold, 0);
        tick(); mem_req = 0; mem_ack = 0; #2; lit("mdu c4", hold, e_hold, 5'b00111);
        tick(); mdu_busy = 0; #2; lit("mdu done", hold, e_hold, 0);

        // Halt during MEM_WAIT
        tick(); idle_in(); mem_req = 1;
        tick(); halt_req = 1; #2; lit("hm wait", hold, e_hold, 5'b01111);
        tick(); mem_ack = 1; #2; lit("hm ack", hold, e_hold, 0);
        lit("hm ack lo", halt_ack, m_ack, 0);
        tick(); mem_req = 0; mem_ack = 0; #2; lit("hm frz", hold, e_hold, 5'b11111);
        tick(); #2; lit("hm ack0", halt_ack, m_ack, 0);
        branch = 1; #2; lit("hm br ign", hold, e_hold, 5'b11111);
        tick(); branch = 0; #2; lit("hm ack1", halt_ack, m_ack, 1);
        halt_req = 0; #2; lit("hm drop frz", hold, e_hold, 5'b11111);
        tick(); #2;
        lit("hm ack off", halt_ack, m_ack, 0);
        lit("hm run", hold, e_hold, 0);

        // Reset mid-MEM_WAIT
        mem_req = 1; tick(); rst = 1; #2;
        lit("rmw flush", flush, e_flush, 5'b11111);
        lit("rmw hold", hold, e_hold, 0);
        tick(); rst = 0; mem_req = 0; #2;
        lit("rmw cnt", stall_cnt, m_cnt, 0);
        lit("rmw err", bus_err, m_err, 0);
        lit("rmw hold2", hold, e_hold, 0);

        // Randomised traffic checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(0, 150) == 0);
            if (!mem_req) mem_req = ($urandom_range(0, 4) == 0);
            else          mem_req = ($urandom_range(0, 5) != 0);
            mem_ack  = mem_req && ($urandom_range(0, 3) == 0);
            if (!mdu_busy) mdu_busy = ($urandom_range(0, 7) == 0);
            else           mdu_busy = ($urandom_range(0, 3) != 0);
            if (!halt_req) halt_req = ($urandom_range(0, 40) == 0);
            else           halt_req = ($urandom_range(0, 5) != 0);
            branch = ($urandom_range(0, 5) == 0);
            ex_ld  = $urandom_range(0, 1);
            ex_rd  = RAW'($urandom_range(0, 3));
            rs1_re = $urandom_range(0, 1);
            rs2_re = $urandom_range(0, 1);
            rs1_a  = RAW'($urandom_range(0, 3));
            rs2_a  = RAW'($urandom_range(0, 3));
        end
        tick(); #2;
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
